// File: rtl/fir_pkg.sv
// Shared definitions for the FIR control path: state encoding, default
// geometry of the 4-MAC datapath and the bank-decode helper.
`timescale 1ns/1ps
package fir_pkg;

  localparam int FIR_NUM_MAC       = 4;
  localparam int FIR_TAPS_PER_MAC  = 10;
  localparam int FIR_MAC_LAT       = 1;
  localparam int FIR_COEF_W        = 16;
  localparam int FIR_TAP_W         = 4;
  // Nominal clocks between 600 kHz sample strobes at 12 MHz.
  localparam int FIR_SAMPLE_PERIOD = 20;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SUM   = 3'd4,
    ST_DONE  = 3'd5
  } fir_state_e;

  // One-hot write enable for the selected MAC coefficient bank.
  function automatic logic [FIR_NUM_MAC-1:0] bank_onehot(input logic [1:0] bank);
    return FIR_NUM_MAC'(1) << bank;
  endfunction

endpackage

// File: rtl/fir_coef_wr_if.sv
// Coefficient write port: captures a held request when the sequencer grants
// an idle cycle, decodes the bank, discards out-of-range taps and acks once.
`timescale 1ns/1ps
module fir_coef_wr_if
  import fir_pkg::*;
#(
  parameter int TAPS_PER_MAC = FIR_TAPS_PER_MAC,
  parameter int TAP_W        = FIR_TAP_W,
  parameter int COEF_W       = FIR_COEF_W
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   idle_grant_i,
  input  logic                   coef_wr_i,
  input  logic [TAP_W+1:0]       coef_addr_i,
  input  logic [COEF_W-1:0]      coef_data_i,
  output logic                   coef_ack_o,
  output logic [FIR_NUM_MAC-1:0] coef_wr_en_o,
  output logic [TAP_W-1:0]       coef_wr_addr_o,
  output logic [COEF_W-1:0]      coef_wr_data_o,
  output logic                   wr_busy_o
);

  logic                   ack_q;
  logic [FIR_NUM_MAC-1:0] wr_en_q;
  logic [FIR_NUM_MAC-1:0] wr_en_d;
  logic [TAP_W-1:0]       addr_q;
  logic [COEF_W-1:0]      data_q;
  logic [1:0]             bank;
  logic [TAP_W-1:0]       tap;
  logic                   tap_ok;
  logic                   accept;

  assign bank   = coef_addr_i[TAP_W+1:TAP_W];
  assign tap    = coef_addr_i[TAP_W-1:0];
  assign tap_ok = ({{(32-TAP_W){1'b0}}, tap} < 32'(TAPS_PER_MAC));
  // The requester still holds its request during the ack cycle, so a
  // pending ack masks re-acceptance to keep it one write per request.
  assign accept = idle_grant_i & coef_wr_i & ~ack_q;

  // Bank enable for an accepted write; an out-of-range tap writes nothing.
  always_comb begin
    wr_en_d = '0;
    if (accept && tap_ok) begin
      wr_en_d = bank_onehot(bank);
    end
  end

  // Register the write strobe, ack and the address/data copy.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ack_q   <= 1'b0;
      wr_en_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      ack_q   <= accept;
      wr_en_q <= wr_en_d;
      if (accept) begin
        addr_q <= tap;
        data_q <= coef_data_i;
      end
    end
  end

  assign coef_ack_o     = ack_q;
  assign coef_wr_en_o   = wr_en_q;
  assign coef_wr_addr_o = addr_q;
  assign coef_wr_data_o = data_q;
  assign wr_busy_o      = ack_q;

endmodule

// File: rtl/fir_ctrl_fsm.sv
// Sequencer for the 4-MAC FIR datapath: one MAC pass per sample strobe
// (clear, tap sweep, drain, sum latch, valid) plus gated coefficient writes.
`timescale 1ns/1ps
module fir_ctrl_fsm
  import fir_pkg::*;
#(
  parameter int TAPS_PER_MAC = FIR_TAPS_PER_MAC,
  parameter int MAC_LAT      = FIR_MAC_LAT,
  parameter int COEF_W       = FIR_COEF_W,
  parameter int TAP_W        = FIR_TAP_W
) (
  input  logic                   iClk12M,
  input  logic                   iRsn,
  input  logic                   iEnSample600k,
  input  logic                   iCoefWr,
  input  logic [TAP_W+1:0]       iCoefAddr,
  input  logic [COEF_W-1:0]      iCoefData,
  output logic                   oCoefAck,
  output logic [FIR_NUM_MAC-1:0] oCoefWrEn,
  output logic [TAP_W-1:0]       oCoefWrAddr,
  output logic [COEF_W-1:0]      oCoefWrData,
  output logic                   oSmplWr,
  output logic                   oMacClr,
  output logic                   oMacEn,
  output logic [TAP_W-1:0]       oTapIdx,
  output logic                   oEnSum,
  output logic                   oFirValid,
  output logic                   oBusy,
  output logic                   oOverrun
);

  localparam logic [TAP_W-1:0] LAST_TAP   = TAP_W'(TAPS_PER_MAC - 1);
  localparam logic [7:0]       LAST_DRAIN = (MAC_LAT > 0) ? 8'(MAC_LAT - 1) : 8'd0;

  fir_state_e       state_q;
  logic [TAP_W-1:0] tap_q;
  logic [7:0]       drain_q;
  logic             smpl_wr_q;
  logic             mac_clr_q;
  logic             mac_en_q;
  logic             en_sum_q;
  logic             fir_valid_q;
  logic             busy_q;
  logic             overrun_q;
  logic             idle_grant;
  logic             coef_busy;

  // A coefficient write may only be taken in IDLE when no sample starts.
  assign idle_grant = (state_q == ST_IDLE) && !iEnSample600k;

  fir_coef_wr_if #(
    .TAPS_PER_MAC (TAPS_PER_MAC),
    .TAP_W        (TAP_W),
    .COEF_W       (COEF_W)
  ) u_coef_wr (
    .clk_i          (iClk12M),
    .rst_n_i        (iRsn),
    .idle_grant_i   (idle_grant),
    .coef_wr_i      (iCoefWr),
    .coef_addr_i    (iCoefAddr),
    .coef_data_i    (iCoefData),
    .coef_ack_o     (oCoefAck),
    .coef_wr_en_o   (oCoefWrEn),
    .coef_wr_addr_o (oCoefWrAddr),
    .coef_wr_data_o (oCoefWrData),
    .wr_busy_o      (coef_busy)
  );

  // Pass sequencer; every output is registered with the state it belongs to.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q     <= ST_IDLE;
      tap_q       <= '0;
      drain_q     <= '0;
      smpl_wr_q   <= 1'b0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      en_sum_q    <= 1'b0;
      fir_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      smpl_wr_q   <= 1'b0;
      mac_clr_q   <= 1'b0;
      en_sum_q    <= 1'b0;
      fir_valid_q <= 1'b0;

      // A strobe that cannot start a pass is dropped and flagged for good.
      if (iEnSample600k && ((state_q != ST_IDLE) || coef_busy)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (iEnSample600k && !coef_busy) begin
            state_q   <= ST_CLR;
            smpl_wr_q <= 1'b1;
            mac_clr_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_CLR: begin
          state_q  <= ST_MAC;
          mac_en_q <= 1'b1;
          tap_q    <= '0;
        end
        ST_MAC: begin
          if (tap_q == LAST_TAP) begin
            mac_en_q <= 1'b0;
            if (MAC_LAT == 0) begin
              state_q  <= ST_SUM;
              en_sum_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
              drain_q <= '0;
            end
          end else begin
            tap_q <= tap_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_q == LAST_DRAIN) begin
            state_q  <= ST_SUM;
            en_sum_q <= 1'b1;
          end else begin
            drain_q <= drain_q + 8'd1;
          end
        end
        ST_SUM: begin
          state_q     <= ST_DONE;
          fir_valid_q <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tap_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tap_q   <= '0;
        end
      endcase
    end
  end

  assign oSmplWr   = smpl_wr_q;
  assign oMacClr   = mac_clr_q;
  assign oMacEn    = mac_en_q;
  assign oTapIdx   = tap_q;
  assign oEnSum    = en_sum_q;
  assign oFirValid = fir_valid_q;
  assign oBusy     = busy_q;
  assign oOverrun  = overrun_q;

endmodule

// File: tb/tb_fir_ctrl_fsm.sv
// Directed bench for the FIR pass sequencer and coefficient write port.
`timescale 1ns/1ps
module tb_fir_ctrl_fsm;
  import fir_pkg::*;

  logic        iClk12M = 1'b0;
  logic        iRsn = 1'b0;
  logic        iEnSample600k = 1'b0;
  logic        iCoefWr = 1'b0;
  logic [5:0]  iCoefAddr = '0;
  logic [15:0] iCoefData = '0;
  logic        oCoefAck;
  logic [3:0]  oCoefWrEn;
  logic [3:0]  oCoefWrAddr;
  logic [15:0] oCoefWrData;
  logic        oSmplWr;
  logic        oMacClr;
  logic        oMacEn;
  logic [3:0]  oTapIdx;
  logic        oEnSum;
  logic        oFirValid;
  logic        oBusy;
  logic        oOverrun;

  int checks = 0;
  int errors = 0;

  fir_ctrl_fsm dut (
    .iClk12M       (iClk12M),
    .iRsn          (iRsn),
    .iEnSample600k (iEnSample600k),
    .iCoefWr       (iCoefWr),
    .iCoefAddr     (iCoefAddr),
    .iCoefData     (iCoefData),
    .oCoefAck      (oCoefAck),
    .oCoefWrEn     (oCoefWrEn),
    .oCoefWrAddr   (oCoefWrAddr),
    .oCoefWrData   (oCoefWrData),
    .oSmplWr       (oSmplWr),
    .oMacClr       (oMacClr),
    .oMacEn        (oMacEn),
    .oTapIdx       (oTapIdx),
    .oEnSum        (oEnSum),
    .oFirValid     (oFirValid),
    .oBusy         (oBusy),
    .oOverrun      (oOverrun)
  );

  always #5 iClk12M = ~iClk12M;

  task automatic tick();
    @(posedge iClk12M);
    #1;
  endtask

  function automatic logic [35:0] all_outs();
    return {oCoefAck, oCoefWrEn, oCoefWrAddr, oCoefWrData, oSmplWr, oMacClr,
            oMacEn, oTapIdx, oEnSum, oFirValid, oBusy, oOverrun};
  endfunction

  task automatic do_reset();
    iRsn = 1'b0;
    iEnSample600k = 1'b0;
    iCoefWr = 1'b0;
    tick();
    tick();
    iRsn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    iRsn = 1'b0;
    tick();
    checks++;
    if (all_outs() !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
    iRsn = 1'b1;
    tick();
    checks++;
    if (all_outs() !== 36'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_single_pass();
    logic [9:0] got;
    logic [9:0] exp;
    logic [3:0] e_tap;
    iEnSample600k = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      iEnSample600k = 1'b0;
      if (c >= 2 && c <= 11) e_tap = 4'(c - 2);
      else if (c >= 12 && c <= 14) e_tap = 4'd9;
      else e_tap = 4'd0;
      exp = {(c == 1), (c == 1), (c >= 2 && c <= 11), e_tap,
             (c == 13), (c == 14), (c >= 1 && c <= 14)};
      got = {oSmplWr, oMacClr, oMacEn, oTapIdx, oEnSum, oFirValid, oBusy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_pass cycle %0d: got %b expected %b", c, got, exp);
      end
    end
    checks++;
    if (oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL single_pass_overrun: got %b expected 0", oOverrun);
    end
  endtask

  task automatic test_periodic();
    int n_valid = 0;
    int n_smpl = 0;
    for (int k = 0; k < 50; k++) begin
      iEnSample600k = 1'b1;
      for (int j = 0; j < FIR_SAMPLE_PERIOD; j++) begin
        tick();
        iEnSample600k = 1'b0;
        if (oFirValid === 1'b1) n_valid++;
        if (oSmplWr === 1'b1) n_smpl++;
      end
    end
    checks++;
    if (n_valid != 50) begin
      errors++;
      $display("FAIL periodic_valid_count: got %0d expected 50", n_valid);
    end
    checks++;
    if (n_smpl != 50) begin
      errors++;
      $display("FAIL periodic_smpl_count: got %0d expected 50", n_smpl);
    end
    checks++;
    if (oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL periodic_overrun: got %b expected 0", oOverrun);
    end
  endtask

  task automatic test_overrun();
    int n_valid = 0;
    int n_smpl = 0;
    iEnSample600k = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      iEnSample600k = (c == 8);
      if (oFirValid === 1'b1) n_valid++;
      if (oSmplWr === 1'b1) n_smpl++;
    end
    checks++;
    if (oOverrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_flag: got %b expected 1", oOverrun);
    end
    checks++;
    if (n_valid != 1) begin
      errors++;
      $display("FAIL overrun_valid_count: got %0d expected 1", n_valid);
    end
    checks++;
    if (n_smpl != 1) begin
      errors++;
      $display("FAIL overrun_smpl_count: got %0d expected 1", n_smpl);
    end
    do_reset();
    checks++;
    if (oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_cleared_by_reset: got %b expected 0", oOverrun);
    end
  endtask

  task automatic test_coef_write();
    iCoefWr = 1'b1;
    iCoefAddr = 6'b10_0011;
    iCoefData = 16'h1234;
    tick();
    checks++;
    if ({oCoefAck, oCoefWrEn, oCoefWrAddr, oCoefWrData} !== {1'b1, 4'b0100, 4'd3, 16'h1234}) begin
      errors++;
      $display("FAIL coef_write: got ack=%b en=%b addr=%0d data=%h expected ack=1 en=0100 addr=3 data=1234",
               oCoefAck, oCoefWrEn, oCoefWrAddr, oCoefWrData);
    end
    iCoefWr = 1'b0;
    tick();
    checks++;
    if ({oCoefAck, oCoefWrEn} !== 5'b0_0000) begin
      errors++;
      $display("FAIL coef_single_ack: got ack=%b en=%b expected ack=0 en=0000", oCoefAck, oCoefWrEn);
    end
    // Tap 10 is out of range for 10 taps per MAC.
    iCoefWr = 1'b1;
    iCoefAddr = 6'b01_1010;
    iCoefData = 16'hABCD;
    tick();
    checks++;
    if ({oCoefAck, oCoefWrEn} !== 5'b1_0000) begin
      errors++;
      $display("FAIL coef_range_discard: got ack=%b en=%b expected ack=1 en=0000", oCoefAck, oCoefWrEn);
    end
    iCoefWr = 1'b0;
    tick();
    // Strobe landing in the write cycle is dropped as an overrun.
    iCoefWr = 1'b1;
    iCoefAddr = 6'b11_0000;
    tick();
    iEnSample600k = 1'b1;
    checks++;
    if ({oCoefAck, oCoefWrEn} !== 5'b1_1000) begin
      errors++;
      $display("FAIL coef_bank3: got ack=%b en=%b expected ack=1 en=1000", oCoefAck, oCoefWrEn);
    end
    iCoefWr = 1'b0;
    tick();
    iEnSample600k = 1'b0;
    checks++;
    if ({oSmplWr, oBusy, oOverrun} !== 3'b001) begin
      errors++;
      $display("FAIL strobe_in_write_cycle: got smpl/busy/ovr=%b expected 001",
               {oSmplWr, oBusy, oOverrun});
    end
    do_reset();
  endtask

  task automatic test_busy_holdoff();
    int ack_cyc;
    int smpl_cyc;
    // Request raised mid-pass.
    ack_cyc = -1;
    iEnSample600k = 1'b1;
    for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
      tick();
      iEnSample600k = 1'b0;
      if (oCoefAck === 1'b1) begin
        ack_cyc = c;
        checks++;
        if (oCoefWrEn !== 4'b0001) begin
          errors++;
          $display("FAIL holdoff_bank: got %b expected 0001", oCoefWrEn);
        end
        iCoefWr = 1'b0;
      end
      if (c == 4) begin
        iCoefWr = 1'b1;
        iCoefAddr = 6'b00_0001;
        iCoefData = 16'hBEEF;
      end
    end
    iCoefWr = 1'b0;
    checks++;
    if (ack_cyc != 16) begin
      errors++;
      $display("FAIL holdoff_ack_cycle: got %0d expected 16", ack_cyc);
    end
    tick();
    tick();
    // Strobe and request in the same idle cycle: the pass goes first.
    ack_cyc = -1;
    smpl_cyc = -1;
    iEnSample600k = 1'b1;
    iCoefWr = 1'b1;
    iCoefAddr = 6'b01_0010;
    iCoefData = 16'h5A5A;
    for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
      tick();
      iEnSample600k = 1'b0;
      if (oSmplWr === 1'b1 && smpl_cyc < 0) smpl_cyc = c;
      if (oCoefAck === 1'b1) begin
        ack_cyc = c;
        iCoefWr = 1'b0;
      end
    end
    iCoefWr = 1'b0;
    checks++;
    if (smpl_cyc != 1) begin
      errors++;
      $display("FAIL same_cycle_sample_first: got %0d expected 1", smpl_cyc);
    end
    checks++;
    if (ack_cyc != 16) begin
      errors++;
      $display("FAIL same_cycle_ack_cycle: got %0d expected 16", ack_cyc);
    end
    checks++;
    if (oOverrun !== 1'b0) begin
      errors++;
      $display("FAIL holdoff_overrun: got %b expected 0", oOverrun);
    end
    tick();
  endtask

  task automatic test_reset_mid_pass();
    int sum_cyc;
    int val_cyc;
    iEnSample600k = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      iEnSample600k = 1'b0;
    end
    checks++;
    if ({oMacEn, oTapIdx} !== {1'b1, 4'd4}) begin
      errors++;
      $display("FAIL mid_pass_state: got en=%b tap=%0d expected en=1 tap=4", oMacEn, oTapIdx);
    end
    #2;
    iRsn = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 36'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h expected 0", all_outs());
    end
    tick();
    tick();
    iRsn = 1'b1;
    sum_cyc = -1;
    val_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (oEnSum === 1'b1 || oFirValid === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL partial_after_reset: got strobe at idle cycle %0d expected none", c);
      end
    end
    iEnSample600k = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      iEnSample600k = 1'b0;
      if (oEnSum === 1'b1) sum_cyc = c;
      if (oFirValid === 1'b1) val_cyc = c;
    end
    checks++;
    if (sum_cyc != 13) begin
      errors++;
      $display("FAIL post_reset_ensum_cycle: got %0d expected 13", sum_cyc);
    end
    checks++;
    if (val_cyc != 14) begin
      errors++;
      $display("FAIL post_reset_valid_cycle: got %0d expected 14", val_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_periodic();
    test_overrun();
    test_coef_write();
    test_busy_holdoff();
    test_reset_mid_pass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000ns");
    $fatal(1);
  end

endmodule
